mem_access_ctrl: RTL

Initiator-side sequencer for the CPU's 512 x 32 data RAM. Accepts single-word read/write requests from the control unit (MAR/MDR datapath) over a valid/ready handshake and converts each one into the RAM's edge-triggered protocol: address and data set up first, then one clean rising edge on `mem_enable`, with read data captured afterwards. It sits between the datapath and the RAM and is the only driver of the RAM's `read`, `write`, `enable`, `addr` and `datain` pins.

---
 rtl/mem_access_ctrl_if.sv | 48 ++++
 rtl/mem_access_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//   Bundles the request/response handshake between the control unit and the
//   memory access controller, together with the RAM pin bus the controller
//   drives.
//
//   modport slave  : controller view (accepts requests, drives the RAM pins)
//   modport master : datapath + RAM view (issues requests, returns dataout)
//
//   Signals:
//     req_valid/req_ready/req_write/req_addr/req_wdata  request handshake
//     resp_valid/resp_err/resp_rdata                    completion
//     mem_addr/mem_datain/mem_read/mem_write/mem_enable RAM control pins
//     mem_dataout                                        RAM read data
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SPACE = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_SPACE-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  logic [ADDR_SPACE-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_datain;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_enable;
  logic [DATA_WIDTH-1:0] mem_dataout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_dataout,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_datain, mem_read, mem_write, mem_enable
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_dataout,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_datain, mem_read, mem_write, mem_enable
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Sequencer that turns single-word read/write requests into the data RAM's
//   edge-triggered protocol: address/data/command are set up for one cycle,
//   mem_enable pulses high for exactly one cycle, then read data is captured
//   and a one-cycle resp_valid is issued.
//
//   Sequence (accept edge = cycle 0):
//     cycle 1 SETUP   : addr/data/command on the pins, enable low
//     cycle 2 STROBE  : enable high (the only state that raises it)
//     cycle 3 CAPTURE : enable low, command/addr held, read data sampled at end
//     cycle 4 DONE    : resp_valid, command dropped
//     cycle 5 IDLE    : req_ready, next request may be accepted
//
//   Ports:
//     clk  - system clock, rising edge
//     clr  - synchronous active-high reset
//     bus  - mem_access_ctrl_if.slave (request, response and RAM pins)
//
//   Optional feature (macro MEM_CTRL_ADDR_CHECK_EN):
//     Requests with req_addr >= ADDR_LIMIT skip the RAM entirely and complete
//     one cycle after accept with resp_err = 1. Without the macro resp_err is
//     constant 0 and every request follows the full sequence.
//
//   All outputs come straight from flops; each *_q is loaded from *_d.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SPACE = 9,
  parameter int ADDR_LIMIT = 512
) (
  input  logic                clk,
  input  logic                clr,
  mem_access_ctrl_if.slave    bus
);

  // ADDR_LIMIT must be representable in ADDR_SPACE+1 bits to be meaningful.
  if (ADDR_LIMIT < 1 || ADDR_LIMIT > (1 << ADDR_SPACE)) begin : g_bad_limit
    $error("mem_access_ctrl: ADDR_LIMIT out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e                state_q,      state_d;
  logic                  req_ready_q,  req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_SPACE-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_datain_q, mem_datain_d;
  logic                  mem_read_q,   mem_read_d;
  logic                  mem_write_q,  mem_write_d;
  logic                  mem_enable_q, mem_enable_d;

  logic                  accept;
  assign accept = bus.req_valid && req_ready_q;

`ifdef MEM_CTRL_ADDR_CHECK_EN
  localparam int LIMIT_W = ADDR_SPACE + 1;
  localparam logic [LIMIT_W-1:0] LIMIT = LIMIT_W'(ADDR_LIMIT);

  logic resp_err_q, resp_err_d;
  logic addr_illegal;
  // Zero-extend so a limit equal to the full address space never matches.
  assign addr_illegal = ({1'b0, bus.req_addr} >= LIMIT);
`endif

  // -------------------------------------------------------------------------
  // Next-state / next-output logic. Outputs are computed for the state being
  // entered so that every pin is a flop output aligned with its state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_enable_d = mem_enable_q;
`ifdef MEM_CTRL_ADDR_CHECK_EN
    resp_err_d   = resp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
`ifdef MEM_CTRL_ADDR_CHECK_EN
          if (addr_illegal) begin
            // Short completion: the RAM pins are left untouched.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = S_DONE;
          end else begin
            mem_addr_d   = bus.req_addr;
            mem_datain_d = bus.req_wdata;
            mem_read_d   = !bus.req_write;
            mem_write_d  = bus.req_write;
            state_d      = S_SETUP;
          end
`else
          mem_addr_d   = bus.req_addr;
          mem_datain_d = bus.req_wdata;
          mem_read_d   = !bus.req_write;
          mem_write_d  = bus.req_write;
          state_d      = S_SETUP;
`endif
        end
      end

      S_SETUP: begin
        // Pins have been stable for a full cycle; raise the strobe.
        mem_enable_d = 1'b1;
        state_d      = S_STROBE;
      end

      S_STROBE: begin
        mem_enable_d = 1'b0;
        state_d      = S_CAPTURE;
      end

      S_CAPTURE: begin
        // The RAM updated dataout on the strobe edge; sample it here so the
        // pins are still held a full cycle after the strobe.
        if (mem_read_q) begin
          resp_rdata_d = bus.mem_dataout;
        end
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b1;
`ifdef MEM_CTRL_ADDR_CHECK_EN
        resp_err_d   = 1'b0;
`endif
        state_d      = S_DONE;
      end

      S_DONE: begin
        resp_valid_d = 1'b0;
`ifdef MEM_CTRL_ADDR_CHECK_EN
        resp_err_d   = 1'b0;
`endif
        req_ready_d  = 1'b1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_enable_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers. Reset aborts any access in flight without a
  // response; a write whose strobe already fired stays in the RAM.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_enable_q <= 1'b0;
`ifdef MEM_CTRL_ADDR_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_enable_q <= mem_enable_d;
`ifdef MEM_CTRL_ADDR_CHECK_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_datain = mem_datain_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_enable = mem_enable_q;
`ifdef MEM_CTRL_ADDR_CHECK_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule
